// File: rtl/therm_count_decoder_pkg.sv
// Shared constants and helpers for the thermometer-to-binary counter family.
// Sized so the same helpers serve the 7-, 15- and 31-input variants.
package therm_pkg;

  localparam int DEF_N = 7;
  localparam int DEF_W = 3;

  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

  // Index of the lowest set bit among the first n bits; n when none is set.
  function automatic int lowest_set(input logic [31:0] vec, input int n);
    int idx;
    idx = n;
    for (int i = n - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/therm_edge_encoder.sv
// Combinational thermometer decoder: count from the lowest one (edge based),
// bubble when the word is not a contiguous run of ones reaching bit N-1.
module therm_edge_encoder
  import therm_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = clog2(N + 1)
) (
  input  logic [N-1:0] therm,
  output logic [W-1:0] count,
  output logic         bubble
);

  int           low;
  logic [N-1:0] ones;
  logic [N-1:0] expected;

  always_comb begin
    low      = lowest_set(32'(therm), N);
    ones     = '1;
    expected = ones << low;
    count    = (low >= N) ? '0 : W'(N - low);
    bubble   = (therm != expected);
  end

endmodule

// File: rtl/therm_count_decoder.sv
// Two-stage thermometer decoder with valid/ready on both sides, bubble
// detection, sticky error flag and a saturating running sum of counts.
module therm_count_decoder
  import therm_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int W     = clog2(N + 1),
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     therm,
  input  logic             acc_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_count,
  output logic             out_bubble,
  output logic [ACC_W-1:0] out_acc,
  output logic             err_sticky
);

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [W-1:0]     b);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + (ACC_W + 1)'(b);
    return sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  endfunction

  logic             vld_p1;
  logic [N-1:0]     therm_p1;
  logic             vld_p2;
  logic [W-1:0]     count_p2;
  logic             bubble_p2;
  logic [ACC_W-1:0] acc_p2;
  logic             err_q;

  logic             s2_free;
  logic             advance;
  logic             accept;
  logic [W-1:0]     enc_count;
  logic             enc_bubble;
  logic [ACC_W-1:0] acc_base;

  therm_edge_encoder #(.N(N), .W(W)) u_enc (
    .therm  (therm_p1),
    .count  (enc_count),
    .bubble (enc_bubble)
  );

  // Ready looks only at pipeline state and out_ready, never at in_valid.
  assign s2_free  = !vld_p2 || out_ready;
  assign advance  = vld_p1 && s2_free;
  assign in_ready = !rst && (!vld_p1 || s2_free);
  assign accept   = in_valid && in_ready;
  assign acc_base = acc_clear ? '0 : acc_p2;

  // Stage 1: capture the raw sorter word
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      therm_p1 <= '0;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      therm_p1 <= therm;
    end else if (advance) begin
      vld_p1   <= 1'b0;
    end
  end

  // Stage 2: decoded count, bubble flag and running sum
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2    <= 1'b0;
      count_p2  <= '0;
      bubble_p2 <= 1'b0;
      acc_p2    <= '0;
      err_q     <= 1'b0;
    end else begin
      if (advance) begin
        vld_p2    <= 1'b1;
        count_p2  <= enc_count;
        bubble_p2 <= enc_bubble;
        acc_p2    <= sat_add(acc_base, enc_count);
      end else begin
        if (out_ready) vld_p2 <= 1'b0;
        if (acc_clear) acc_p2 <= '0;
      end
      if (advance && enc_bubble) err_q <= 1'b1;
      else if (acc_clear)        err_q <= 1'b0;
    end
  end

  assign out_valid  = vld_p2;
  assign out_count  = count_p2;
  assign out_bubble = bubble_p2;
  assign out_acc    = acc_p2;
  assign err_sticky = err_q;

endmodule
